alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter: SHAMT_WIDTH, default 5, shift-amount width, equal to log2(DATA_WIDTH).
REQ-003 Port: clk, input, 1, single clock; all state changes on rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-006 Port: Operation, input, 4, op select from the ALU controller.
REQ-007 Port: SrcA, input, DATA_WIDTH, operand A.
REQ-008 Port: SrcB, input, DATA_WIDTH, operand B; shift amount is SrcB[SHAMT_WIDTH-1:0].
REQ-009 Port: busy, output, 1, high while an accepted operation is incomplete; pipeline stalls on it.
REQ-010 Port: done, output, 1, one-cycle pulse when ALUResult is valid.
REQ-011 Port: ALUResult, output, DATA_WIDTH, registered result; holds until the next done.

Function
REQ-012 Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 SUB, 0110 SRA, 1100 XOR, 1111 SLT (signed), 1000 BEQ, 1001 BNE, 1010 BLT (signed), 1011 BGE (signed).
REQ-013 Branch ops: ALUResult = 1 if condition true, else 0.
REQ-014 SLT: ALUResult = 1 if signed SrcA < SrcB, else 0.
REQ-015 Unlisted codes (0111, 1101, 1110): ALUResult = 0, with normal single-op latency.
REQ-016 ADD/SUB: modulo 2^DATA_WIDTH; carry and overflow discarded.
REQ-017 States: IDLE, SHIFT, DONE.
REQ-018 IDLE, start=1, non-shift op: latch result, go to DONE; done=1 in the cycle after start.
REQ-019 IDLE, start=1, shift op, shamt>0: latch SrcA and shamt into internal registers, go to SHIFT.
REQ-020 SHIFT: one bit per cycle (SLL left zero-fill; SRL right zero-fill; SRA right sign-fill); counter decrements; at count 1, final shift is applied, go to DONE.
REQ-021 Shift op with shamt=0: handled as non-shift; ALUResult = SrcA, done the next cycle.
REQ-022 Latency start-to-done: 1 cycle for non-shift; shamt cycles for shifts, maximum 31.
REQ-023 DONE: done=1 for exactly one cycle, then return to IDLE; the next start is accepted in that IDLE cycle.
REQ-024 busy=1 from the cycle after accepted start through the done cycle inclusive; busy=0 in IDLE.
REQ-025 start while not IDLE: ignored, no queuing; SrcA/SrcB/Operation changes after acceptance do not affect the in-flight op.
REQ-026 start held continuously: a new op is accepted every IDLE cycle (back-to-back, one idle cycle between done pulses).
REQ-027 ALUResult updates only on the done cycle; otherwise it holds its last value.

Reset
REQ-028 reset low: immediately, regardless of clock, state=IDLE, busy=0, done=0, ALUResult=0, counter=0, shift register=0.
REQ-029 Reset mid-SHIFT: op abandoned, no done pulse; first start after reset release proceeds normally.
REQ-030 Reset release: takes effect at the next rising edge; start sampled on that edge is accepted.

Verification
REQ-031 ADD: SrcA=0x7FFFFFFF, SrcB=1, Op=0010, start -> next cycle done=1, ALUResult=0x80000000.
REQ-032 SRA: SrcA=0x80000000, SrcB=31, Op=0110 -> busy for 31 cycles, done on cycle 31, ALUResult=0xFFFFFFFF; SRL same inputs -> 0x00000001.
REQ-033 SLT/BLT: SrcA=0xFFFFFFFF, SrcB=1, Op=1111 -> 1; Op=1011 (BGE) -> 0; Op=1000 with SrcA=SrcB=5 -> 1.
REQ-034 Ignore-while-busy: SLL SrcA=1, SrcB=4; start with ADD pulsed in cycle 2 -> single done at cycle 4, ALUResult=0x10; no second done.
REQ-035 Reset mid-shift: SLL shamt=20, reset low at cycle 5 -> busy=0, done=0, ALUResult=0 at once; after release, OR 0xF0|0x0F -> 0xFF one cycle after start.
REQ-036 Shamt zero/unlisted: SLL SrcA=0xABCD, SrcB=0x20 (shamt 0) -> 0xABCD in 1 cycle; Op=1101 -> 0 in 1 cycle.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arithmetic/compare ops, shifts performed one bit per cycle.
// ALUResult is registered and qualified by a one-cycle done pulse; busy covers the whole operation.
module alu_iter #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] ALUResult
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0101;
   localparam logic [3:0] OP_SRA = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b1100;
   localparam logic [3:0] OP_SLT = 4'b1111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BNE = 4'b1001;
   localparam logic [3:0] OP_BLT = 4'b1010;
   localparam logic [3:0] OP_BGE = 4'b1011;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   shreg, shreg_nxt;
   logic [SHAMT_WIDTH-1:0]  cnt, cnt_nxt;
   logic [3:0]              sh_op, sh_op_nxt;
   logic [DATA_WIDTH-1:0]   result_nxt;
   logic [SHAMT_WIDTH-1:0]  shamt;
   logic [DATA_WIDTH-1:0]   first_shift;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift1(input logic [3:0] op,
                                                    input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, v[DATA_WIDTH-1:1]};
         OP_SRA:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] flag(input logic f);
      return {{(DATA_WIDTH-1){1'b0}}, f};
   endfunction

   // Single-cycle result; a shift reaching here has a zero amount and passes SrcA through.
   function automatic logic [DATA_WIDTH-1:0] alu_comb(input logic [3:0] op,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      logic signed [DATA_WIDTH-1:0] sa;
      logic signed [DATA_WIDTH-1:0] sb;
      logic [DATA_WIDTH-1:0]        r;
      sa = a;
      sb = b;
      case (op)
         OP_AND:                 r = a & b;
         OP_OR:                  r = a | b;
         OP_XOR:                 r = a ^ b;
         OP_ADD:                 r = a + b;
         OP_SUB:                 r = a - b;
         OP_SLL, OP_SRL, OP_SRA: r = a;
         OP_SLT, OP_BLT:         r = flag(sa < sb);
         OP_BGE:                 r = flag(sa >= sb);
         OP_BEQ:                 r = flag(a == b);
         OP_BNE:                 r = flag(a != b);
         default:                r = '0;
      endcase
      return r;
   endfunction

   assign shamt       = SrcB[SHAMT_WIDTH-1:0];
   assign first_shift = shift1(Operation, SrcA);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   // The first bit is shifted on acceptance, so start-to-done latency equals the shift amount.
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      cnt_nxt    = cnt;
      sh_op_nxt  = sh_op;
      result_nxt = ALUResult;
      case (state)
         IDLE: begin
            if (start) begin
               if (is_shift(Operation) && (shamt != '0)) begin
                  sh_op_nxt = Operation;
                  shreg_nxt = first_shift;
                  cnt_nxt   = shamt - SHAMT_WIDTH'(1);
                  if (shamt == SHAMT_WIDTH'(1)) begin
                     result_nxt = first_shift;
                     state_nxt  = DONE;
                  end else begin
                     state_nxt  = SHIFT;
                  end
               end else begin
                  result_nxt = alu_comb(Operation, SrcA, SrcB);
                  state_nxt  = DONE;
               end
            end
         end
         SHIFT: begin
            shreg_nxt = shift1(sh_op, shreg);
            cnt_nxt   = cnt - SHAMT_WIDTH'(1);
            if (cnt == SHAMT_WIDTH'(1)) begin
               result_nxt = shreg_nxt;
               state_nxt  = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         sh_op     <= '0;
         ALUResult <= '0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         cnt       <= cnt_nxt;
         sh_op     <= sh_op_nxt;
         ALUResult <= result_nxt;
      end
   end

endmodule
